// File: rtl/i2c_pkg.sv
// Shared types and constants for the two-requester I2C master arbiter.
package i2c_pkg;

  localparam int NREQ      = 2;
  localparam int LEN_W_DEF = 4;

  typedef logic [$clog2(NREQ)-1:0] req_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_XFER,
    S_STOP,
    S_DONE
  } state_t;

endpackage

// File: rtl/i2c_rr_arb.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not served last.
module i2c_rr_arb
  import i2c_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  req_idx_t        last,
  output logic [NREQ-1:0] grant
);

  // One-hot grant decode
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == req_idx_t'(1)) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates two requesters onto one byte-level I2C master and sequences
// start / byte transfers / stop for the granted requester.
// Optional feature: define I2C_ARB_TIMEOUT_EN to add a per-byte watchdog that
// aborts a stalled transfer (nack + done) after TIMEOUT cycles.
//
// state | meaning
// IDLE  | waiting for master idle and a request
// LOAD  | grant held, transaction fields latched, first write byte consumed
// START | m_start pulse
// XFER  | counting bytes on m_byte_done, abort on m_nack
// STOP  | m_stop held until the master reports idle
// DONE  | done (and nack on abort) pulse, grant released at exit
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       rd_wr,
  input  logic [6:0]       addr0,
  input  logic [6:0]       addr1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       wdata0,
  input  logic [7:0]       wdata1,
  output logic [1:0]       gnt,
  output logic [1:0]       wdata_ack,
  output logic [7:0]       rdata,
  output logic [1:0]       rdata_valid,
  output logic [1:0]       done,
  output logic [1:0]       nack,
  output logic             m_start,
  output logic             m_stop,
  output logic             m_rd_wr,
  output logic [6:0]       m_address,
  output logic [7:0]       m_din,
  input  logic [7:0]       m_dout,
  input  logic             m_byte_done,
  input  logic             m_nack,
  input  logic             m_idle
);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q;
  req_idx_t         idx_q;
  req_idx_t         last_q;
  logic [LEN_W-1:0] rem_q;
  logic [6:0]       m_addr_q;
  logic             m_rw_q;
  logic [7:0]       m_din_q;
  logic [7:0]       rdata_q;
  logic [1:0]       wack_q;
  logic [1:0]       rvalid_q;
  logic             abort_q;

  logic [1:0]       arb_gnt;
  req_idx_t         arb_idx;
  logic [6:0]       addr_sel;
  logic [LEN_W-1:0] len_sel;
  logic [7:0]       wdata_new;
  logic [7:0]       wdata_cur;
  logic             byte_ev;
  logic             abort_ev;
  logic             last_byte;
  logic             tmo_hit;

  i2c_rr_arb u_arb (
    .req   (req),
    .last  (last_q),
    .grant (arb_gnt)
  );

  assign arb_idx   = req_idx_t'(arb_gnt[1]);
  assign addr_sel  = arb_idx[0] ? addr1 : addr0;
  assign len_sel   = arb_idx[0] ? len1 : len0;
  assign wdata_new = arb_idx[0] ? wdata1 : wdata0;
  assign wdata_cur = idx_q[0] ? wdata1 : wdata0;

  // A nack in the same cycle as a byte completion wins: the byte is dropped.
  assign abort_ev  = (state_q == S_XFER) && (m_nack || tmo_hit);
  assign byte_ev   = (state_q == S_XFER) && m_byte_done && !abort_ev;
  assign last_byte = byte_ev && (rem_q == LEN_W'(1));

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  // Per-byte watchdog: reloads on START and every byte, counts down in XFER
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= TW'(TIMEOUT);
    end else if (state_q == S_START || (state_q == S_XFER && m_byte_done)) begin
      tmo_q <= TW'(TIMEOUT);
    end else if (state_q == S_XFER && tmo_q != '0) begin
      tmo_q <= tmo_q - TW'(1);
    end
  end

  assign tmo_hit = (state_q == S_XFER) && (tmo_q == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (m_idle && (req != 2'b00)) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_XFER;
      S_XFER:  if (abort_ev || last_byte) state_d = S_STOP;
      S_STOP:  if (m_idle) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction datapath: grant, latched fields, byte counting, data pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= '0;
      idx_q    <= '0;
      last_q   <= req_idx_t'(1);
      rem_q    <= '0;
      m_addr_q <= '0;
      m_rw_q   <= 1'b0;
      m_din_q  <= '0;
      rdata_q  <= '0;
      wack_q   <= '0;
      rvalid_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      wack_q   <= '0;
      rvalid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_LOAD) begin
            gnt_q    <= arb_gnt;
            idx_q    <= arb_idx;
            last_q   <= arb_idx;
            m_rw_q   <= rd_wr[arb_idx];
            m_addr_q <= addr_sel;
            rem_q    <= (len_sel == '0) ? LEN_W'(1) : len_sel;
            abort_q  <= 1'b0;
            if (rd_wr[arb_idx]) m_din_q <= wdata_new;
          end
        end
        S_XFER: begin
          if (abort_ev) begin
            abort_q <= 1'b1;
          end else if (byte_ev) begin
            rem_q <= rem_q - LEN_W'(1);
            if (!m_rw_q) begin
              rdata_q  <= m_dout;
              rvalid_q <= gnt_q;
            end else if (rem_q > LEN_W'(1)) begin
              m_din_q <= wdata_cur;
              wack_q  <= gnt_q;
            end
          end
        end
        S_DONE: gnt_q <= '0;
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    m_start     = (state_q == S_START);
    m_stop      = (state_q == S_STOP);
    done        = (state_q == S_DONE) ? gnt_q : 2'b00;
    nack        = (state_q == S_DONE && abort_q) ? gnt_q : 2'b00;
    wdata_ack   = wack_q | ((state_q == S_LOAD && m_rw_q) ? gnt_q : 2'b00);
    rdata_valid = rvalid_q;
    gnt         = gnt_q;
    rdata       = rdata_q;
    m_rd_wr     = m_rw_q;
    m_address   = m_addr_q;
    m_din       = m_din_q;
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: writes, reads, round-robin ties, nack aborts
// and mid-transfer reset, with hand-computed expectations.
module tb_i2c_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] rd_wr;
  logic [6:0] addr0, addr1;
  logic [3:0] len0, len1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt, wdata_ack, rdata_valid, done, nack;
  logic [7:0] rdata;
  logic       m_start, m_stop, m_rd_wr;
  logic [6:0] m_address;
  logic [7:0] m_din;
  logic [7:0] m_dout;
  logic       m_byte_done, m_nack, m_idle;

  int checks;
  int failures;

  i2c_arbiter #(.LEN_W(4), .TIMEOUT(1023)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rd_wr       (rd_wr),
    .addr0       (addr0),
    .addr1       (addr1),
    .len0        (len0),
    .len1        (len1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt         (gnt),
    .wdata_ack   (wdata_ack),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .nack        (nack),
    .m_start     (m_start),
    .m_stop      (m_stop),
    .m_rd_wr     (m_rd_wr),
    .m_address   (m_address),
    .m_din       (m_din),
    .m_dout      (m_dout),
    .m_byte_done (m_byte_done),
    .m_nack      (m_nack),
    .m_idle      (m_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From LOAD: run a single-byte transaction to IDLE
  task automatic finish_one(input string tag, input logic [1:0] exp_gnt);
    tick();
    check({tag, "_start"}, 32'(m_start), 32'h1);
    m_idle = 1'b0;
    tick();
    m_byte_done = 1'b1;
    tick();
    check({tag, "_stop"}, 32'(m_stop), 32'h1);
    m_byte_done = 1'b0;
    m_idle = 1'b1;
    tick();
    check({tag, "_done"}, 32'(done), 32'(exp_gnt));
    tick();
    check({tag, "_gnt_off"}, 32'(gnt), 32'h0);
  endtask

  initial begin
    logic [7:0] rvals [3];
    checks = 0;
    failures = 0;
    rvals[0] = 8'h11; rvals[1] = 8'h22; rvals[2] = 8'h33;
    reset = 1'b1; req = 2'b00; rd_wr = 2'b00;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    wdata0 = '0; wdata1 = '0; m_dout = '0;
    m_byte_done = 1'b0; m_nack = 1'b0; m_idle = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_gnt",   32'(gnt),       32'h0);
    check("rst_start", 32'(m_start),   32'h0);
    check("rst_stop",  32'(m_stop),    32'h0);
    check("rst_addr",  32'(m_address), 32'h0);
    check("rst_din",   32'(m_din),     32'h0);
    check("rst_done",  32'(done),      32'h0);

    // Write from req0: 2 bytes A5, 3C
    req = 2'b01; rd_wr = 2'b01; addr0 = 7'h50; len0 = 4'd2; wdata0 = 8'hA5;
    tick();
    check("w_gnt",   32'(gnt),       32'h1);
    check("w_ack0",  32'(wdata_ack), 32'h1);
    check("w_din0",  32'(m_din),     32'hA5);
    check("w_addr",  32'(m_address), 32'h50);
    check("w_rw",    32'(m_rd_wr),   32'h1);
    wdata0 = 8'h3C;
    tick();
    check("w_start", 32'(m_start),   32'h1);
    check("w_ack_s", 32'(wdata_ack), 32'h0);
    m_idle = 1'b0;
    tick();
    check("w_start_off", 32'(m_start), 32'h0);
    m_byte_done = 1'b1;
    tick();
    check("w_din1",  32'(m_din),     32'h3C);
    check("w_ack1",  32'(wdata_ack), 32'h1);
    check("w_nostop",32'(m_stop),    32'h0);
    m_byte_done = 1'b0;
    tick();
    check("w_ack1_off", 32'(wdata_ack), 32'h0);
    m_byte_done = 1'b1;
    tick();
    check("w_stop",  32'(m_stop),    32'h1);
    check("w_noack", 32'(wdata_ack), 32'h0);
    m_byte_done = 1'b0;
    tick();
    check("w_stop_hold", 32'(m_stop), 32'h1);
    check("w_nodone",    32'(done),   32'h0);
    m_idle = 1'b1;
    tick();
    check("w_done",  32'(done), 32'h1);
    check("w_nack",  32'(nack), 32'h0);
    check("w_addr_hold", 32'(m_address), 32'h50);
    req = 2'b00;
    tick();
    check("w_done_off", 32'(done), 32'h0);
    check("w_gnt_off",  32'(gnt),  32'h0);

    // Read from req1: 3 bytes
    req = 2'b10; rd_wr = 2'b00; addr1 = 7'h2A; len1 = 4'd3;
    tick();
    check("r_gnt",  32'(gnt),       32'h2);
    check("r_ack",  32'(wdata_ack), 32'h0);
    check("r_rw",   32'(m_rd_wr),   32'h0);
    check("r_addr", 32'(m_address), 32'h2A);
    tick();
    m_idle = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      m_dout = rvals[i];
      m_byte_done = 1'b1;
      tick();
      check("r_data",  32'(rdata),       32'(rvals[i]));
      check("r_valid", 32'(rdata_valid), 32'h2);
      m_byte_done = 1'b0;
      tick();
      check("r_valid_off", 32'(rdata_valid), 32'h0);
    end
    check("r_stop", 32'(m_stop), 32'h1);
    m_idle = 1'b1;
    req = 2'b00;
    tick();
    check("r_done", 32'(done), 32'h2);
    check("r_nack", 32'(nack), 32'h0);
    tick();

    // Ties from reset: req0, req1, req0; len 0 treated as one byte
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 2'b11; rd_wr = 2'b00; len0 = 4'd0; len1 = 4'd0;
    tick();
    check("tie1_gnt", 32'(gnt), 32'h1);
    finish_one("tie1", 2'b01);
    tick();
    check("tie2_gnt", 32'(gnt), 32'h2);
    finish_one("tie2", 2'b10);
    tick();
    check("tie3_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    finish_one("tie3", 2'b01);

    // Nack on first byte of a 4-byte write
    req = 2'b01; rd_wr = 2'b01; len0 = 4'd4; wdata0 = 8'h77;
    tick();
    check("n_ack_load", 32'(wdata_ack), 32'h1);
    tick();
    m_idle = 1'b0;
    tick();
    m_nack = 1'b1;
    tick();
    check("n_stop",  32'(m_stop),    32'h1);
    check("n_noack", 32'(wdata_ack), 32'h0);
    check("n_din",   32'(m_din),     32'h77);
    m_nack = 1'b0;
    m_idle = 1'b1;
    req = 2'b00;
    tick();
    check("n_done", 32'(done), 32'h1);
    check("n_nack", 32'(nack), 32'h1);
    tick();
    check("n_nack_off", 32'(nack), 32'h0);

    // Byte done and nack together on a read: nack wins
    req = 2'b10; rd_wr = 2'b00; len1 = 4'd2;
    tick();
    tick();
    m_idle = 1'b0;
    tick();
    m_dout = 8'h99; m_byte_done = 1'b1; m_nack = 1'b1;
    tick();
    check("bn_valid", 32'(rdata_valid), 32'h0);
    check("bn_rdata", 32'(rdata),       32'h33);
    check("bn_stop",  32'(m_stop),      32'h1);
    m_byte_done = 1'b0; m_nack = 1'b0; m_idle = 1'b1; req = 2'b00;
    tick();
    check("bn_done", 32'(done), 32'h2);
    check("bn_nack", 32'(nack), 32'h2);
    tick();

    // Reset in the middle of a 3-byte write
    req = 2'b01; rd_wr = 2'b01; len0 = 4'd3; addr0 = 7'h1B; wdata0 = 8'h5A;
    tick();
    tick();
    m_idle = 1'b0;
    tick();
    m_byte_done = 1'b1;
    tick();
    check("rx_ack", 32'(wdata_ack), 32'h1);
    m_byte_done = 1'b0;
    reset = 1'b1;
    tick();
    check("rx_gnt",   32'(gnt),       32'h0);
    check("rx_stop",  32'(m_stop),    32'h0);
    check("rx_start", 32'(m_start),   32'h0);
    check("rx_addr",  32'(m_address), 32'h0);
    check("rx_din",   32'(m_din),     32'h0);
    check("rx_rw",    32'(m_rd_wr),   32'h0);
    check("rx_rdata", 32'(rdata),     32'h0);
    check("rx_ack0",  32'(wdata_ack), 32'h0);
    check("rx_done",  32'(done),      32'h0);
    check("rx_nack",  32'(nack),      32'h0);
    reset = 1'b0;
    m_idle = 1'b1;
    len0 = 4'd0;
    tick();
    check("rx_regnt", 32'(gnt),       32'h1);
    check("rx_readdr",32'(m_address), 32'h1B);
    check("rx_nodone",32'(done),      32'h0);
    req = 2'b00;
    finish_one("rx_after", 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter LEN_W, default 4, meaning the width of the byte-count field (max 15 bytes per transaction).
REQ-002 SHALL have parameter TIMEOUT, default 1023, meaning the watchdog limit in clk cycles per byte (used only under REQ-027).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, all logic on posedge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req[1:0]  in  2  per-requester transaction request, level.
REQ-006 rd_wr[1:0]  in  2  per-requester direction, 1=write, 0=read.
REQ-007 addr0, addr1  in  7 each  per-requester 7-bit slave address.
REQ-008 len0, len1  in  LEN_W each  per-requester byte count; 0 is treated as 1.
REQ-009 wdata0, wdata1  in  8 each  per-requester next write byte.
REQ-010 gnt[1:0]  out  2  one-hot grant, held for the whole transaction.
REQ-011 wdata_ack[1:0]  out  2  one-cycle pulse: wdataN consumed, present the next byte.
REQ-012 rdata  out  8  last read byte; rdata_valid[1:0]  out  2  one-cycle pulse to the granted requester.
REQ-013 done[1:0], nack[1:0]  out  2 each  one-cycle end-of-transaction pulses; nack is coincident with done on abort.
REQ-014 Master side: m_start, m_stop, m_rd_wr  out  1 each; m_address  out  7; m_din  out  8; m_dout  in  8; m_byte_done  in  1 (pulse per byte incl. ack); m_nack  in  1 (pulse); m_idle  in  1 (level).

Function
REQ-015 FSM states: IDLE, LOAD, START, XFER, STOP, DONE.
- IDLE->LOAD when m_idle=1 and req!=0.
- LOAD->START after 1 cycle.
- START->XFER after 1 cycle.
- XFER->STOP on last byte or nack.
- STOP->DONE when m_idle=1.
- DONE->IDLE after 1 cycle.
REQ-016 Arbitration in IDLE: single request is granted; with both requesting, grant the requester not served last; the last-served pointer resets to 1 so req[0] wins the first tie.
REQ-017 LOAD: assert gnt; latch rd_wr, address and len (0->1) into remaining; for a write, latch wdataN into m_din and pulse wdata_ack for one cycle.
REQ-018 START: m_start=1 for exactly one cycle; m_address and m_rd_wr stay stable from LOAD until DONE.
REQ-019 XFER, on m_byte_done: decrement remaining.
- Read: rdata<=m_dout and pulse rdata_valid.
- Write with remaining>1 before the decrement: load the next wdataN into m_din and pulse wdata_ack.
REQ-020 When remaining reaches 0, m_stop=1 and is held through STOP until m_idle=1.
REQ-021 m_nack during XFER aborts: go to STOP, and nack pulses together with done in DONE.
REQ-022 Simultaneous m_byte_done and m_nack: nack wins; the byte is not counted and neither rdata_valid nor wdata_ack pulses.
REQ-023 DONE: pulse done for the granted requester; gnt deasserts on the DONE->IDLE edge; a new grant is possible no earlier than 1 cycle after DONE.
REQ-024 Deassertion of req mid-transaction is ignored; the transaction runs to completion.

Reset
REQ-025 On reset the next edge forces:
- state=IDLE, last-served=1, remaining=0;
- gnt, wdata_ack, rdata_valid, done, nack all 0;
- m_start, m_stop, m_rd_wr all 0; m_address=0, m_din=0, rdata=0.
REQ-026 Reset asserted mid-transaction aborts with no done or nack pulse.

Configuration
REQ-027 Macro I2C_ARB_TIMEOUT_EN:
- Defined: a per-byte counter clears on START and on each m_byte_done; reaching TIMEOUT in XFER aborts as per REQ-021 (nack+done).
- Undefined: no counter logic; XFER waits indefinitely.

Structure
REQ-028 Shared package i2c_pkg SHALL hold the FSM state enum, NREQ=2, the requester-index typedef and the default LEN_W.
REQ-029 The two-way round-robin grant logic SHALL be a sub-module i2c_rr_arb (inputs req, last; output one-hot grant).

Verification
REQ-030 Write from req0: len0=2, addr0=0x50, bytes 0xA5 then 0x3C -> m_start 1 cycle; m_din=0xA5, then 0x3C after the first m_byte_done; wdata_ack[0] pulses twice; m_stop after the 2nd byte; done[0] once.
REQ-031 Read from req1: len1=3, m_dout=0x11,0x22,0x33 -> three rdata_valid[1] pulses with rdata matching each value; done[1]; nack[1]=0.
REQ-032 Both req asserted at the same edge, from reset -> req0 served first, then req1; a second tie is granted to req0 again.
REQ-033 m_nack on the 1st byte of len=4 -> m_stop asserts; done and nack pulse in the same cycle; no further wdata_ack.
REQ-034 m_byte_done and m_nack in the same cycle -> no rdata_valid; abort as in REQ-033.
REQ-035 Reset during XFER -> all outputs at reset values next cycle; no done; next request is served normally.
